mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 clk  input  1  clock; all state changes on the rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 dec_valid  input  1  the instruction register holds a supported opcode.
REQ-004 dec_branch  input  1  b/beq/bne: no register write-back.
REQ-005 dec_link  input  1  bl/jirl: register write plus PC redirect.
REQ-006 dec_load / dec_store  input  1 each  ld.w / st.w.
REQ-007 br_taken  input  1  branch condition from the datapath; only meaningful in ID and WB.
REQ-008 inst_req / inst_ack  output / input  1 each  fetch handshake.
REQ-009 data_req / data_ack  output / input  1 each  data handshake.
REQ-010 data_we  output  1  store qualifier; valid only while data_req=1.
REQ-011 ir_we, pc_we, pc_sel, rf_we  output  1 each  datapath enables; pc_sel selects the next PC: 0 = pc+4, 1 = branch target.
REQ-012 retire  output  1  one-cycle pulse per completed instruction.
REQ-013 state  output  3  current state encoding.
REQ-014 halted  output  1  sticky illegal-instruction halt flag.
REQ-015 retired_cnt, wait_cnt  output  32 each  performance counters.

Function
REQ-016 The FSM states SHALL be IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
REQ-017 IF: inst_req=1; when inst_ack=1, ir_we=1 for that cycle, then go to ID; otherwise stay in IF.
REQ-018 ID transitions:
- dec_valid=0: go to HALT, with no enables asserted.
- dec_branch=1: pc_we=1, pc_sel=br_taken, retire=1, then go to IF.
- otherwise: go to EXE.
REQ-019 EXE transitions: dec_load or dec_store goes to MEM; otherwise go to WB.
REQ-020 MEM: data_req=1 and data_we=dec_store; when data_ack=1:
- store: pc_we=1, pc_sel=0, retire=1, then go to IF.
- load: go to WB.
REQ-021 WB: rf_we=1, pc_we=1, pc_sel=dec_link&br_taken, retire=1, then go to IF.
REQ-022 HALT: absorbing; every request and enable is 0; halted=1 until reset.
REQ-023 All enables and requests SHALL be combinational from the state and current inputs, and 0 in every state or condition not listed above.
REQ-024 An ack arriving in the same cycle its request first rises SHALL be accepted (zero-wait).
REQ-025 An ack arriving while the matching request is 0 SHALL be ignored.
REQ-026 Latencies with zero-wait acks:
- branch: 2 cycles.
- ALU/link: 4 cycles.
- store: 4 cycles.
- load: 5 cycles.
REQ-027 retired_cnt SHALL increment by 1 per retire pulse and wrap modulo 2^32.
REQ-028 wait_cnt SHALL increment for every cycle in which (inst_req & ~inst_ack) | (data_req & ~data_ack), and wrap modulo 2^32.
REQ-029 Decode inputs SHALL be held stable by the datapath from ID through WB; the unit does not register them.

Reset
REQ-030 While reset=1, all requests and enables SHALL be forced to 0, regardless of state.
REQ-031 On a clock edge with reset=1: state becomes IF, halted=0, and both counters become 0.
REQ-032 Reset asserted mid-transaction (IF/MEM waiting, or HALT) SHALL abandon the transaction; a late ack after reset is handled per REQ-025/REQ-017.
REQ-033 The first inst_req SHALL assert in the first cycle with reset=0.

Structure
REQ-034 Package mc_pkg SHALL hold the 3-bit state type and constants (IF..HALT) and the counter width (32); the datapath top shares this package.
REQ-035 A single sub-module mc_perf_counter (32-bit, synchronous clear, increment enable) SHALL be instantiated twice.
REQ-036 Target size is 150-250 lines of RTL, with no latches.

Verification
REQ-037 Add with zero-wait acks: states IF,ID,EXE,WB,IF; rf_we=1 and pc_we=1 only in WB; retired_cnt goes 0 to 1 after 4 cycles.
REQ-038 beq taken (br_taken=1) in ID: pc_we=1, pc_sel=1, retire=1 in ID; next state IF; rf_we stays 0 throughout.
REQ-039 ld.w with data_ack delayed 3 cycles: data_req=1 for 4 cycles; wait_cnt=3; rf_we pulses once in WB; total 8 cycles IF to IF.
REQ-040 st.w with zero wait: data_we=1 only in MEM; pc_sel=0; no WB state visited; retire=1 in MEM.
REQ-041 dec_valid=0 in ID: state=5 and halted=1 next cycle; inst_req stays 0 for 10 cycles; reset then yields state=0, halted=0, counters 0.
REQ-042 Reset asserted during MEM with data_ack low, then data_ack=1 after reset: no data_req or retire; state=IF; the stray ack is ignored.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control unit and its datapath.
//   mc_state_e : 3-bit FSM state encoding (IF..HALT), also exported on the
//                debug state output.
//   CNT_W      : width of the performance counters.
package mc_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EXE  = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } mc_state_e;

endpackage

// File: rtl/mc_perf_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^W.
//   clk   : clock
//   clr_i : synchronous clear (wins over increment)
//   inc_i : add one on this edge
//   cnt_o : current count
module mc_perf_counter
  import mc_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: IF -> ID -> (EXE -> (MEM) -> (WB)) -> IF, with an
// absorbing HALT on an unsupported opcode.
// Handshakes: a request (inst_req/data_req) is held high until the matching
// ack is seen in the same cycle; an ack is only consumed in a cycle where its
// request is high (so zero-wait acks work and stray acks are ignored).
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   dec_valid/branch/link/load/store : decode of the held instruction
//   br_taken                         : branch condition from the datapath
//   inst_req/inst_ack                : fetch handshake
//   data_req/data_ack, data_we       : data handshake, store qualifier
//   ir_we, pc_we, pc_sel, rf_we      : datapath enables (pc_sel 1 = target)
//   retire                           : one pulse per completed instruction
//   state, halted                    : debug state, sticky halt flag
//   retired_cnt, wait_cnt            : performance counters
module mc_control_unit
  import mc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic             dec_branch,
  input  logic             dec_link,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             br_taken,
  output logic             inst_req,
  input  logic             inst_ack,
  output logic             data_req,
  input  logic             data_ack,
  output logic             data_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             retire,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  mc_state_e state_q, state_d;
  logic      halted_q, halted_d;
  logic      wait_inc;

  always_comb begin
    state_d  = state_q;
    inst_req = 1'b0;
    ir_we    = 1'b0;
    data_req = 1'b0;
    data_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;

    case (state_q)
      ST_IF: begin
        inst_req = 1'b1;
        if (inst_ack) begin
          ir_we   = 1'b1;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        if (!dec_valid) begin
          state_d = ST_HALT;
        end else if (dec_branch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken;
          retire  = 1'b1;
          state_d = ST_IF;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        state_d = (dec_load || dec_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        data_req = 1'b1;
        data_we  = dec_store;
        if (data_ack) begin
          if (dec_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = dec_link & br_taken;
        retire  = 1'b1;
        state_d = ST_IF;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // Unused encodings recover to fetch.
        state_d = ST_IF;
      end
    endcase

    // Reset masks every request/enable combinationally, whatever the state.
    if (reset) begin
      state_d  = ST_IF;
      inst_req = 1'b0;
      ir_we    = 1'b0;
      data_req = 1'b0;
      data_we  = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      rf_we    = 1'b0;
      retire   = 1'b0;
    end
  end

  // Sticky: set on entry to HALT, cleared only by reset.
  assign halted_d = reset ? 1'b0 : (halted_q | (state_d == ST_HALT));

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    halted_q <= halted_d;
  end

  assign state    = state_q;
  assign halted   = halted_q;
  assign wait_inc = (inst_req & ~inst_ack) | (data_req & ~data_ack);

  mc_perf_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .clr_i (reset),
    .inc_i (retire),
    .cnt_o (retired_cnt)
  );

  mc_perf_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .clr_i (reset),
    .inc_i (wait_inc),
    .cnt_o (wait_cnt)
  );

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

  // Output flag masks, order: inst_req ir_we data_req data_we pc_we pc_sel rf_we retire halted
  localparam logic [8:0] F_IREQ = 9'b100000000;
  localparam logic [8:0] F_IRWE = 9'b010000000;
  localparam logic [8:0] F_DREQ = 9'b001000000;
  localparam logic [8:0] F_DWE  = 9'b000100000;
  localparam logic [8:0] F_PCWE = 9'b000010000;
  localparam logic [8:0] F_PSEL = 9'b000001000;
  localparam logic [8:0] F_RFWE = 9'b000000100;
  localparam logic [8:0] F_RET  = 9'b000000010;
  localparam logic [8:0] F_HLT  = 9'b000000001;
  localparam logic [8:0] F_NONE = 9'b000000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_valid = 1'b0, dec_branch = 1'b0, dec_link = 1'b0;
  logic        dec_load = 1'b0, dec_store = 1'b0, br_taken = 1'b0;
  logic        inst_ack = 1'b0, data_ack = 1'b0;
  logic        inst_req, data_req, data_we, ir_we, pc_we, pc_sel, rf_we, retire;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] retired_cnt, wait_cnt;

  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ret = 0;
  logic [31:0] exp_wait = 0;

  mc_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_branch  (dec_branch),
    .dec_link    (dec_link),
    .dec_load    (dec_load),
    .dec_store   (dec_store),
    .br_taken    (br_taken),
    .inst_req    (inst_req),
    .inst_ack    (inst_ack),
    .data_req    (data_req),
    .data_ack    (data_ack),
    .data_we     (data_we),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .rf_we       (rf_we),
    .retire      (retire),
    .state       (state),
    .halted      (halted),
    .retired_cnt (retired_cnt),
    .wait_cnt    (wait_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: act=%h exp=%h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] row(input logic [2:0] st, input logic [8:0] f);
    return {st, f};
  endfunction

  // One clock cycle: drive inputs (just after posedge), push expected output
  // row, compare at negedge, advance to just after the next posedge.
  task automatic do_cycle(input string tag, input logic rst, input logic ia,
                          input logic da, input logic [11:0] exp);
    logic [11:0] obs;
    reset = rst; inst_ack = ia; data_ack = da;
    exp_q.push_back(exp);
    @(negedge clk);
    obs = {state, inst_req, ir_we, data_req, data_we, pc_we, pc_sel, rf_we, retire, halted};
    check_val(tag, {20'd0, obs}, {20'd0, exp_q.pop_front()});
    @(posedge clk); #1;
  endtask

  task automatic check_counters(input string tag);
    check_val({tag, "_retired_cnt"}, retired_cnt, exp_ret);
    check_val({tag, "_wait_cnt"}, wait_cnt, exp_wait);
  endtask

  // ---------------- driver tasks ----------------
  // Fetch with iw wait cycles; a stray data_ack is held high while waiting.
  task automatic fetch(input int iw);
    for (int i = 0; i < iw; i++) begin
      do_cycle("if_wait", 1'b0, 1'b0, 1'b1, row(S_IF, F_IREQ));
      exp_wait++;
    end
    do_cycle("if_ack", 1'b0, 1'b1, 1'b0, row(S_IF, F_IREQ | F_IRWE));
  endtask

  task automatic set_dec(input logic v, input logic b, input logic l,
                         input logic ld, input logic st, input logic tk);
    dec_valid = v; dec_branch = b; dec_link = l;
    dec_load = ld; dec_store = st; br_taken = tk;
  endtask

  task automatic run_alu(input int iw, input logic link, input logic taken);
    set_dec(1'b1, 1'b0, link, 1'b0, 1'b0, taken);
    fetch(iw);
    do_cycle("alu_id", 1'b0, 1'b0, 1'b0, row(S_ID, F_NONE));
    do_cycle("alu_exe", 1'b0, 1'b0, 1'b0, row(S_EXE, F_NONE));
    do_cycle("alu_wb", 1'b0, 1'b0, 1'b0,
             row(S_WB, F_RFWE | F_PCWE | F_RET | ((link & taken) ? F_PSEL : F_NONE)));
    exp_ret++;
    check_counters("alu");
  endtask

  task automatic run_branch(input int iw, input logic taken);
    set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, taken);
    fetch(iw);
    do_cycle("br_id", 1'b0, 1'b0, 1'b0,
             row(S_ID, F_PCWE | F_RET | (taken ? F_PSEL : F_NONE)));
    exp_ret++;
    check_val("br_next_state", {29'd0, state}, {29'd0, S_IF});
    check_counters("br");
  endtask

  task automatic run_mem(input int iw, input int dw, input logic store, input logic taken);
    logic [8:0] mf;
    set_dec(1'b1, 1'b0, 1'b0, ~store, store, taken);
    mf = F_DREQ | (store ? F_DWE : F_NONE);
    fetch(iw);
    do_cycle("mem_id", 1'b0, 1'b0, 1'b0, row(S_ID, F_NONE));
    do_cycle("mem_exe", 1'b0, 1'b0, 1'b0, row(S_EXE, F_NONE));
    for (int i = 0; i < dw; i++) begin
      do_cycle("mem_wait", 1'b0, 1'b1, 1'b0, row(S_MEM, mf));
      exp_wait++;
    end
    if (store) begin
      do_cycle("st_ack", 1'b0, 1'b0, 1'b1, row(S_MEM, mf | F_PCWE | F_RET));
      exp_ret++;
      check_val("st_no_wb", {29'd0, state}, {29'd0, S_IF});
    end else begin
      do_cycle("ld_ack", 1'b0, 1'b0, 1'b1, row(S_MEM, mf));
      do_cycle("ld_wb", 1'b0, 1'b0, 1'b0, row(S_WB, F_RFWE | F_PCWE | F_RET));
      exp_ret++;
    end
    check_counters(store ? "st" : "ld");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_cycle("reset_row", 1'b1, 1'b1, 1'b1, row(S_IF, F_NONE));
    check_counters("reset");

    // First cycle out of reset must already request a fetch (added inside fetch).
    run_alu(0, 1'b0, 1'b0);            // add, zero wait
    run_branch(0, 1'b1);               // beq taken
    run_branch(1, 1'b0);               // bne not taken
    run_alu(0, 1'b1, 1'b1);            // bl: link with redirect
    run_mem(0, 3, 1'b0, 1'b0);         // ld.w, data_ack 3 cycles late
    run_mem(0, 0, 1'b1, 1'b0);         // st.w zero wait
    run_alu(2, 1'b0, 1'b1);            // add with fetch waits, br_taken ignored

    // Illegal opcode -> HALT, absorbing, all requests low.
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(0);
    do_cycle("ill_id", 1'b0, 1'b0, 1'b0, row(S_ID, F_NONE));
    for (int i = 0; i < 10; i++) begin
      do_cycle("halt", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               row(S_HALT, F_HLT));
    end
    check_counters("halt");
    do_cycle("halt_reset", 1'b1, 1'b0, 1'b0, row(S_HALT, F_HLT));
    exp_ret = 0; exp_wait = 0;
    check_counters("after_halt_reset");
    run_alu(0, 1'b0, 1'b0);

    // Reset during MEM wait, stray data_ack afterwards.
    set_dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    fetch(0);
    do_cycle("abort_id", 1'b0, 1'b0, 1'b0, row(S_ID, F_NONE));
    do_cycle("abort_exe", 1'b0, 1'b0, 1'b0, row(S_EXE, F_NONE));
    do_cycle("abort_mem", 1'b0, 1'b0, 1'b0, row(S_MEM, F_DREQ));
    do_cycle("abort_rst", 1'b1, 1'b0, 1'b0, row(S_MEM, F_NONE));
    exp_ret = 0; exp_wait = 0;
    do_cycle("stray_ack", 1'b0, 1'b0, 1'b1, row(S_IF, F_IREQ));
    exp_wait++;
    check_counters("stray");
    run_mem(0, 1, 1'b0, 1'b0);

    // Random mix of instructions and wait states.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: run_alu($urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)));
        1: run_alu($urandom_range(0, 2), 1'b1, 1'($urandom_range(0, 1)));
        2: run_branch($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        3: run_mem($urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 1'b0);
        default: run_mem($urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b0);
      endcase
    end

    check_val("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
